// File: rtl/lcd_host.sv
// lcd_host: issues a buffered 4-bit command script to the LCD controller, then captures its IRAM write stream.
// Latency: first cmd_valid two edges after start; store/wr_count/checksum/host_done update one edge after their input.
// Backpressure: waits on busy (plus a one-cycle gap per command); script pushes while full are dropped. Watchdog macro: LCD_HOST_TIMEOUT_EN.

// lcd_host_fifo: synchronous FIFO with combinational head output.
// Latency: a pushed entry becomes the head one edge after the push.
// Backpressure: push accepted when not full, or when full and popping in the same cycle.
module lcd_host_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd  = rd_rdy && !empty;
  assign do_wr  = wr_vld && (!full || do_rd);
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_rd) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end
endmodule

module lcd_host #(
  parameter int CMD_DEPTH = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        script_wr,
  input  logic [3:0]  script_cmd,
  input  logic        start,
  output logic        script_full,
  output logic        overflow,
  output logic [3:0]  cmd,
  output logic        cmd_valid,
  input  logic        busy,
  input  logic        IRAM_valid,
  input  logic [5:0]  IRAM_A,
  input  logic [7:0]  IRAM_D,
  input  logic        done,
  input  logic [5:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic [6:0]  wr_count,
  output logic [13:0] checksum,
  output logic        host_done,
  output logic        timeout
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  logic [2:0] state;
  logic [3:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       push_drop;
  logic       beat;
  logic       tmo_hit;
  logic [7:0] store [64];

  // The command being issued is already latched in cmd, so ISSUE only has to retire the head.
  assign fifo_pop    = (state == S_ISSUE);
  assign push_drop   = script_wr && fifo_full && !fifo_pop;
  assign script_full = fifo_full;
  assign beat        = (state == S_CAPTURE) && IRAM_valid;
  assign rd_data     = store[rd_addr];

  lcd_host_fifo #(
    .W     (4),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (script_wr),
    .wr_dat (script_cmd),
    .rd_rdy (fifo_pop),
    .rd_dat (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cmd       <= 4'd0;
      cmd_valid <= 1'b0;
      overflow  <= 1'b0;
      wr_count  <= 7'd0;
      checksum  <= 14'd0;
      host_done <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      if (push_drop) overflow <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start && !fifo_empty) state <= S_WAIT;
        end
        S_WAIT: begin
          if (fifo_empty) begin
            state <= S_IDLE;
          end else if (!busy) begin
            state     <= S_ISSUE;
            cmd       <= fifo_head;
            cmd_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          state <= (cmd == 4'd0) ? S_CAPTURE : S_GAP;
        end
        // busy is not looked at here: the controller raises it a cycle late.
        S_GAP: begin
          state <= S_WAIT;
        end
        S_CAPTURE: begin
          if (IRAM_valid) begin
            if (wr_count != 7'd64) wr_count <= wr_count + 7'd1;
            checksum <= checksum + {6'd0, IRAM_D};
          end
          if (done || tmo_hit) begin
            state     <= S_FINISH;
            host_done <= 1'b1;
          end
        end
        S_FINISH: begin
          state <= S_FINISH;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat) store[IRAM_A] <= IRAM_D;
  end

`ifdef LCD_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == S_CAPTURE) && !done && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else if (state == S_ISSUE) begin
      tmo_cnt <= '0;
    end else if (state == S_CAPTURE) begin
      tmo_cnt <= tmo_cnt + {{(TW-1){1'b0}}, 1'b1};
      if (tmo_hit) timeout <= 1'b1;
    end
  end
`else
  // Watchdog compiled out; TIMEOUT is kept so both builds share one parameter list.
  localparam int unused_timeout = TIMEOUT;

  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule
